// File: rtl/act_quant_pkg.sv
// Shared accelerator parameters: default lane geometry and config field widths
// used by act_quant, max_pool and the neighbouring stream blocks.
package act_quant_pkg;

    localparam int DW_DEF  = 8;   // output lane width
    localparam int DN_DEF  = 6;   // parallel lanes
    localparam int AW_DEF  = 32;  // accumulator lane width
    localparam int BW_DEF  = 16;  // bias lane width
    localparam int SHIFT_W = 5;   // cfg_shift width
    localparam int LEN_W   = 12;  // cfg_len / beat counter width

endpackage

// File: rtl/quant_lane.sv
// One lane of requantisation: round-half-up arithmetic shift, optional ReLU,
// then saturation to a signed DW-bit result. Purely combinational.
module quant_lane
    import act_quant_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic signed [AW:0]        sum,
    input  logic        [SHIFT_W-1:0] shift,
    input  logic                      relu,
    output logic        [DW-1:0]      q
);

    // One guard bit above the bias-added sum keeps the rounding add exact.
    localparam int RW = AW + 2;
    localparam int QMAX_I = (1 << (DW - 1)) - 1;
    localparam logic signed [RW-1:0] QMAX = RW'(QMAX_I);
    localparam logic signed [RW-1:0] QMIN = RW'(-QMAX_I - 1);

    logic signed [RW-1:0] ext;
    logic signed [RW-1:0] rnd;
    logic signed [RW-1:0] r;

    // NOTE: combinational blocks use blocking '=' and assign every output first, so r can be refined step by step without inferring a latch.
    always_comb begin
        ext = {sum[AW], sum};
        rnd = '0;
        if (shift != '0) begin
            rnd = RW'(1) << (shift - 1'b1);
        end
        r = (ext + rnd) >>> shift;
        if (relu && r < 0) begin
            r = '0;
        end
        if (r > QMAX) begin
            q = QMAX[DW-1:0];
        end else if (r < QMIN) begin
            q = QMIN[DW-1:0];
        end else begin
            q = r[DW-1:0];
        end
    end

endmodule

// File: rtl/act_quant.sv
// Activation requantiser: S1 adds per-lane bias, S2 rounds/shifts/ReLUs/saturates.
// Valid/ready on both sides, 1 beat/cycle, s_last marks the end of each cfg_len row.
module act_quant
    import act_quant_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int DN = DN_DEF,
    parameter int AW = AW_DEF,
    parameter int BW = BW_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DN*AW-1:0]     m_data,
    input  logic                 m_valid,
    output logic                 m_ready,
    input  logic [DN*BW-1:0]     cfg_bias,
    input  logic [SHIFT_W-1:0]   cfg_shift,
    input  logic                 cfg_relu,
    input  logic [LEN_W-1:0]     cfg_len,
    output logic [DN*DW-1:0]     s_data,
    output logic                 s_valid,
    input  logic                 s_ready,
    output logic                 s_last
);

    logic                  s1_valid;
    logic [DN-1:0][AW:0]   s1_sum;
    logic [DN-1:0][AW:0]   sum_next;
    logic [DN*DW-1:0]      q_data;
    logic                  s2_adv;
    logic                  s1_adv;
    logic [LEN_W-1:0]      cnt;

    // Each stage moves when it is empty or its consumer takes its beat this cycle.
    assign s2_adv  = !s_valid || s_ready;
    assign s1_adv  = !s1_valid || s2_adv;
    assign m_ready = s1_adv;

    // cfg_len = 0 wraps to 4095 here, giving a 4096-beat row.
    assign s_last = s_valid && (cnt == cfg_len - LEN_W'(1));

    always_comb begin
        for (int k = 0; k < DN; k++) begin
            sum_next[k] = {m_data[k*AW + AW-1], m_data[k*AW +: AW]}
                        + {{(AW + 1 - BW){cfg_bias[k*BW + BW-1]}}, cfg_bias[k*BW +: BW]};
        end
    end

    // NOTE: data registers are reset as well as the valid flags so s_data is never X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
        end else if (s1_adv) begin
            s1_valid <= m_valid;
            if (m_valid) begin
                s1_sum <= sum_next;
            end
        end
    end

    for (genvar g = 0; g < DN; g++) begin : g_lane
        quant_lane #(
            .AW (AW),
            .DW (DW)
        ) u_quant_lane (
            .sum   (s1_sum[g]),
            .shift (cfg_shift),
            .relu  (cfg_relu),
            .q     (q_data[g*DW +: DW])
        );
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid <= 1'b0;
            s_data  <= '0;
        end else if (s2_adv) begin
            s_valid <= s1_valid;
            if (s1_valid) begin
                s_data <= q_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (s_valid && s_ready) begin
            cnt <= s_last ? '0 : cnt + LEN_W'(1);
        end
    end

endmodule

// File: doc/act_quant.md
ACT_QUANT -- requirements
Module: act_quant

Interface
REQ-001 Parameter DW, default 8, output lane width (signed two's complement).
REQ-002 Parameter DN, default 6, number of parallel lanes.
REQ-003 Parameter AW, default 32, accumulator lane width (signed).
REQ-004 Parameter BW, default 16, bias lane width (signed).
REQ-005 The block SHALL expose these ports: clk input 1, the single clock; rst_n input 1, reset, asynchronous and active-low.
REQ-006 m_data input DN*AW, accumulator results, lane i at [i*AW +: AW]; m_valid input 1; m_ready output 1.
REQ-007 cfg_bias input DN*BW, per-lane bias, lane i at [i*BW +: BW]; cfg_shift input 5, right-shift amount; cfg_relu input 1, ReLU enable; cfg_len input 12, beats per row.
REQ-008 s_data output DN*DW, quantised lanes, same lane order; s_valid output 1; s_ready input 1; s_last output 1, marks the final beat of a row.

Function
REQ-009 Input and output handshakes SHALL be valid/ready: transfer on valid&&ready; valid never depends on ready; data/valid held stable while valid&&!ready.
REQ-010 Two registered stages: S1 = bias add, S2 = round/shift/ReLU/saturate; latency m-accept to s_valid = 2 cycles with s_ready high; throughput 1 beat/cycle.
REQ-011 S2 advances when S2 is empty or s_ready=1; S1 advances when S1 is empty or S2 advances; m_ready = S1 empty || S2 advances (combinational, no bubble at full rate).
REQ-012 S1 per lane: sum = sext(m_lane, AW+1) + sext(bias_lane, AW+1); no overflow possible.
REQ-013 S2 per lane: cfg_shift=0 -> r = sum; else r = (sum + 2^(cfg_shift-1)) >>> cfg_shift (arithmetic, round-half-up).
REQ-014 S2 ReLU: cfg_relu=1 and r<0 -> r = 0.
REQ-015 S2 saturation: r > 2^(DW-1)-1 -> 2^(DW-1)-1; r < -2^(DW-1) -> -2^(DW-1); else r[DW-1:0].
REQ-016 Lanes SHALL be independent; one lane saturating does not affect others.
REQ-017 Beat counter cnt (12 bit) increments on each output transfer; s_last = s_valid && cnt==cfg_len-1; on that transfer cnt wraps to 0.
REQ-018 cfg_len=0 SHALL behave as 4096 (natural 12-bit wrap).
REQ-019 cfg_* SHALL be static while any stage holds valid data; changing them mid-row is undefined except that cnt is never corrupted beyond wrap.
REQ-020 Simultaneous S2 drain and S1 refill in one cycle SHALL occur without data loss or duplication.

Reset
REQ-021 On rst_n low (any cycle, asynchronous): S1/S2 valid flags = 0, s_valid = 0, s_last = 0, s_data = 0, cnt = 0; m_ready = 1 once rst_n is high.
REQ-022 Reset mid-row discards in-flight beats; first beat after reset starts a new row (cnt=0).
REQ-023 Data registers SHALL also reset to 0 so s_data is deterministic.

Structure
REQ-024 Per-lane round/ReLU/saturate SHALL be one sub-module, quant_lane (combinational, parameters AW, DW), instantiated DN times via generate.
REQ-025 Default DW/DN/AW/BW values and the cfg_shift/cfg_len widths SHALL live in the shared accelerator parameter package used by max_pool and its neighbours.
REQ-026 s_data/s_valid feed max_pool m_data/m_valid directly; no extra register slice between them.

Verification
REQ-027 Lane0 m=1000, bias=24, shift=3, relu=0 -> lane0 out = 127 (1024>>3=128, saturated); m=100, bias=0, shift=3 -> 13 (rounding 12.5 up).
REQ-028 m=-300, bias=0, shift=0: relu=0 -> -128; relu=1 -> 0; m=-4, shift=1 -> -2 with relu=0.
REQ-029 Stream 10 beats, s_ready=1, m_valid=1 continuous -> outputs on cycles 2..11, m_ready never low, order preserved.
REQ-030 s_ready low for 5 cycles mid-stream -> m_ready drops after S1/S2 fill, no beat lost/duplicated, s_data stable while stalled.
REQ-031 cfg_len=4, 12 beats -> s_last on beats 3, 7, 11 only; cfg_len=0 with 4097 beats -> s_last only on beat 4095.
REQ-032 rst_n pulsed low with 2 beats in flight -> s_valid=0 immediately, next input row restarts s_last count at 0.
